// File: rtl/pe_mac_cell.sv
// ============================================================================
// Module      : pe_mac_cell
// Description : Systolic-array processing element that forwards operands down
//               and right, and accumulates programmable-length dot products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_cell #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b0,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic              clear_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] up_i,
    input  logic [DATA_W-1:0] left_i,
    output logic [DATA_W-1:0] down_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    output logic [ACC_W-1:0]  res_o,
    output logic              done_o,
    output logic              ovf_o
);

    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("pe_mac_cell: ACC_W must be at least 2*DATA_W");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] c_SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] c_UMAX = {ACC_W{1'b1}};

    state_t             r_state, w_state_nxt, w_state_cur;
    logic [DATA_W-1:0]  r_down, r_right;
    logic               r_valid;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic               r_ovf_acc, w_ovf_acc_nxt;
    logic [ACC_W-1:0]   r_res, w_res_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_done, w_complete;

    logic               w_beat;
    logic [LEN_W-1:0]   w_len_sel;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W:0]     w_sum_full;
    logic               w_add_ovf;
    logic [ACC_W-1:0]   w_sum_sat;
    logic               w_ovf_acc_upd;

    // Product width is 2*DATA_W; the size cast extends according to signedness.
    if (SIGNED) begin : g_signed
        logic signed [2*DATA_W-1:0] w_prod_s;
        assign w_prod_s   = $signed(up_i) * $signed(left_i);
        assign w_prod_ext = ACC_W'(w_prod_s);
        assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                            (w_sum_full[ACC_W-1] != r_acc[ACC_W-1]);
    end else begin : g_unsigned
        logic [2*DATA_W-1:0] w_prod_u;
        assign w_prod_u   = up_i * left_i;
        assign w_prod_ext = ACC_W'(w_prod_u);
        assign w_add_ovf  = w_sum_full[ACC_W];
    end

    assign w_sum_full = {1'b0, r_acc} + {1'b0, w_prod_ext};

    // Signed overflow direction follows the common operand sign (taken from acc).
    always_comb begin
        w_sum_sat = w_sum_full[ACC_W-1:0];
        if (SAT && w_add_ovf) begin
            if (!SIGNED)
                w_sum_sat = c_UMAX;
            else if (r_acc[ACC_W-1])
                w_sum_sat = c_SMIN;
            else
                w_sum_sat = c_SMAX;
        end
    end

    assign w_beat        = en_i & valid_i;
    assign w_len_sel     = (len_i == '0) ? LEN_W'(1) : len_i;
    assign w_cnt_inc     = r_cnt + LEN_W'(1);
    assign w_ovf_acc_upd = r_ovf_acc | w_add_ovf;
    assign w_state_cur   = (en_i && clear_i) ? ST_IDLE : r_state;

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_ovf_acc_nxt = r_ovf_acc;
        w_res_nxt     = r_res;
        w_ovf_nxt     = r_ovf;
        w_complete    = 1'b0;

        if (en_i && clear_i) begin
            w_state_nxt   = ST_IDLE;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_ovf_acc_nxt = 1'b0;
        end

        if (w_beat) begin
            case (w_state_cur)
                ST_IDLE: begin
                    w_len_nxt     = w_len_sel;
                    w_acc_nxt     = w_prod_ext;
                    w_cnt_nxt     = LEN_W'(1);
                    w_ovf_acc_nxt = 1'b0;
                    if (w_len_sel == LEN_W'(1)) begin
                        w_complete  = 1'b1;
                        w_res_nxt   = w_prod_ext;
                        w_ovf_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end
                ST_ACC: begin
                    w_acc_nxt     = w_sum_sat;
                    w_ovf_acc_nxt = w_ovf_acc_upd;
                    w_cnt_nxt     = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_complete  = 1'b1;
                        w_res_nxt   = w_sum_sat;
                        w_ovf_nxt   = w_ovf_acc_upd;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= ST_IDLE;
        else if (en_i)
            r_state <= w_state_nxt;
    end

    // done is not gated by en_i so the pulse always lasts exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_down    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_ovf_acc <= 1'b0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (en_i) begin
                r_down    <= up_i;
                r_right   <= left_i;
                r_valid   <= valid_i;
                r_acc     <= w_acc_nxt;
                r_cnt     <= w_cnt_nxt;
                r_len     <= w_len_nxt;
                r_ovf_acc <= w_ovf_acc_nxt;
                r_res     <= w_res_nxt;
                r_ovf     <= w_ovf_nxt;
            end
        end
    end

    assign down_o  = r_down;
    assign right_o = r_right;
    assign valid_o = r_valid;
    assign res_o   = r_res;
    assign done_o  = r_done;
    assign ovf_o   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_cell.sv
// ============================================================================
// Module      : tb_pe_mac_cell
// Description : Directed self-checking bench for pe_mac_cell, covering the
//               default build and three 8-bit/16-bit variants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_mac_cell;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, valid, clear;
    logic [7:0]  len;
    logic [31:0] up32, left32;
    logic [7:0]  up8, left8;

    logic [31:0] down32, right32;
    logic        vo32, done32, ovf32;
    logic [63:0] res32;

    logic [7:0]  down_s, right_s, down_w, right_w, down_u, right_u;
    logic        vo_s, vo_w, vo_u, done_s, done_w, done_u, ovf_s, ovf_w, ovf_u;
    logic [15:0] res_s, res_w, res_u;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_mac_cell u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .clear_i(clear),
        .len_i(len), .up_i(up32), .left_i(left32), .down_o(down32), .right_o(right32),
        .valid_o(vo32), .res_o(res32), .done_o(done32), .ovf_o(ovf32)
    );

    pe_mac_cell #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b1)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .clear_i(clear),
        .len_i(len), .up_i(up8), .left_i(left8), .down_o(down_s), .right_o(right_s),
        .valid_o(vo_s), .res_o(res_s), .done_o(done_s), .ovf_o(ovf_s)
    );

    pe_mac_cell #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b0)) u_dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .clear_i(clear),
        .len_i(len), .up_i(up8), .left_i(left8), .down_o(down_w), .right_o(right_w),
        .valid_o(vo_w), .res_o(res_w), .done_o(done_w), .ovf_o(ovf_w)
    );

    pe_mac_cell #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SAT(1'b0)) u_dut_uns (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .clear_i(clear),
        .len_i(len), .up_i(up8), .left_i(left8), .down_o(down_u), .right_o(right_u),
        .valid_o(vo_u), .res_o(res_u), .done_o(done_u), .ovf_o(ovf_u)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; clear = 1'b0; len = 8'd0;
        up32 = '0; left32 = '0; up8 = '0; left8 = '0;
        step();
        step();
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic beat32(input logic [31:0] a, input logic [31:0] b);
        up32 = a; left32 = b; valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (res32 !== 64'd0) begin bad++; $display("FAIL reset_res got %0d want 0", res32); end
        total++; if ({down32, right32, vo32, done32, ovf32} !== '0) begin bad++; $display("FAIL reset_outs got %h want 0", {down32, right32, vo32, done32, ovf32}); end
        total++; if ({res_s, res_w, res_u} !== '0) begin bad++; $display("FAIL reset_res8 got %h want 0", {res_s, res_w, res_u}); end
    endtask

    task automatic test_single();
        len = 8'd1;
        beat32(32'd2, 32'd7);
        total++; if (res32 !== 64'd14) begin bad++; $display("FAIL single_res got %0d want 14", res32); end
        total++; if (done32 !== 1'b1 || ovf32 !== 1'b0) begin bad++; $display("FAIL single_flags got done=%b ovf=%b want done=1 ovf=0", done32, ovf32); end
        total++; if (down32 !== 32'd2 || right32 !== 32'd7 || vo32 !== 1'b1) begin bad++; $display("FAIL single_fwd got %0d/%0d/%b want 2/7/1", down32, right32, vo32); end
        step();
        total++; if (done32 !== 1'b0 || res32 !== 64'd14 || vo32 !== 1'b0) begin bad++; $display("FAIL single_after got done=%b res=%0d vo=%b want 0/14/0", done32, res32, vo32); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        do_reset();
        len = 8'd3;
        beat32(32'd2, 32'd7);
        pulses += int'(done32);
        beat32(32'd3, 32'd4);
        pulses += int'(done32);
        len = 8'd9;  // must be ignored mid dot product
        beat32(32'hFFFF_FFFF, 32'd5);
        pulses += int'(done32);
        total++; if (res32 !== 64'd21 || done32 !== 1'b1) begin bad++; $display("FAIL dot3_res got res=%0d done=%b want 21/1", res32, done32); end
        len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            beat32(32'd1, 32'd1);
            pulses += int'(done32);
            total++; if (res32 !== ((i == 2) ? 64'd3 : 64'd21)) begin bad++; $display("FAIL b2b_res%0d got %0d", i, res32); end
        end
        step();
        pulses += int'(done32);
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    endtask

    task automatic test_stall();
        do_reset();
        len = 8'd3;
        beat32(32'd2, 32'd7);
        beat32(32'd3, 32'd4);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = i[0]; up32 = 32'd100 + i; left32 = 32'd200 + i;
            step();
            total++; if (down32 !== 32'd3 || right32 !== 32'd4 || vo32 !== 1'b1 || done32 !== 1'b0 || res32 !== 64'd0) begin bad++; $display("FAIL stall_hold%0d got %0d/%0d/%b/%b/%0d want 3/4/1/0/0", i, down32, right32, vo32, done32, res32); end
        end
        en = 1'b1;
        beat32(32'hFFFF_FFFF, 32'd5);
        total++; if (res32 !== 64'd21 || done32 !== 1'b1) begin bad++; $display("FAIL stall_res got res=%0d done=%b want 21/1", res32, done32); end
    endtask

    task automatic test_overflow();
        do_reset();
        len = 8'd3;
        up8 = 8'd127; left8 = 8'd127;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        total++; if (res_s !== 16'd32767 || ovf_s !== 1'b1) begin bad++; $display("FAIL sat_res got %0d ovf=%b want 32767/1", res_s, ovf_s); end
        total++; if ($signed(res_w) !== -16'sd17149 || ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_res got %0d ovf=%b want -17149/1", $signed(res_w), ovf_w); end
        total++; if (res_u !== 16'd48387 || ovf_u !== 1'b0) begin bad++; $display("FAIL uns_sum got %0d ovf=%b want 48387/0", res_u, ovf_u); end
    endtask

    task automatic test_unsigned();
        do_reset();
        len = 8'd1;
        up8 = 8'd255; left8 = 8'd255; valid = 1'b1;
        step();
        valid = 1'b0;
        total++; if (res_u !== 16'd65025 || ovf_u !== 1'b0 || done_u !== 1'b1) begin bad++; $display("FAIL uns_res got %0d ovf=%b done=%b want 65025/0/1", res_u, ovf_u, done_u); end
        total++; if (res_s !== 16'd1) begin bad++; $display("FAIL sgn_neg1sq got %0d want 1", res_s); end
    endtask

    task automatic test_clear();
        do_reset();
        len = 8'd4;
        beat32(32'd1, 32'd1);
        beat32(32'd1, 32'd1);
        clear = 1'b1; len = 8'd1;
        beat32(32'd5, 32'd5);
        total++; if (res32 !== 64'd25 || done32 !== 1'b1) begin bad++; $display("FAIL clear_beat got res=%0d done=%b want 25/1", res32, done32); end
        step();
        clear = 1'b0;
        total++; if (res32 !== 64'd25 || done32 !== 1'b0) begin bad++; $display("FAIL clear_hold got res=%0d done=%b want 25/0", res32, done32); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        len = 8'd4;
        beat32(32'd3, 32'd4);
        beat32(32'd3, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({res32, down32, right32, vo32, done32, ovf32} !== '0) begin bad++; $display("FAIL async_rst got %h want 0", {res32, down32, right32, vo32, done32, ovf32}); end
        step();
        rst_n = 1'b1;
        len = 8'd1;
        beat32(32'd3, 32'd3);
        total++; if (res32 !== 64'd9 || done32 !== 1'b1) begin bad++; $display("FAIL rst_restart got res=%0d done=%b want 9/1", res32, done32); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_unsigned();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
